rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 19 +
 rtl/rom_arbiter_rr_picker.sv | 20 ++
 rtl/rom_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
package rom_arbiter_pkg;

    // Number of requesters sharing the ROM port.
    localparam int unsigned NREQ = 2;

    // Transaction sequencing: accept, let the ROM sample, return response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Index of the set bit in a two-requester one-hot vector.
    function automatic logic onehot_to_idx(input logic [NREQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// Round-robin choice between two requesters.
module rr_picker
    import rom_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic            i_last,
    output logic [NREQ-1:0] o_pick
);

    // On contention the requester not served last wins; otherwise pass the lone request through.
    always_comb begin
        o_pick = '0;
        if (i_req[0] && i_req[1]) begin
            o_pick = i_last ? 2'b01 : 2'b10;
        end else begin
            o_pick = i_req;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port genrom.
// One transaction every three cycles: grant, ROM sample, response.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter  int unsigned MEM_ADDR  = 4,
    parameter  int unsigned MEM_EXTRA = 4,
    localparam int unsigned DW        = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [MEM_ADDR:0]    req_addr0,
    input  logic [MEM_ADDR:0]    req_addr1,
    input  logic [MEM_EXTRA-1:0] req_extra0,
    input  logic [MEM_EXTRA-1:0] req_extra1,
    input  logic [MEM_ADDR:0]    req_lb0,
    input  logic [MEM_ADDR:0]    req_ub0,
    input  logic [MEM_ADDR:0]    req_lb1,
    input  logic [MEM_ADDR:0]    req_ub1,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_error,
    output logic [MEM_ADDR:0]    mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [MEM_ADDR:0]    mem_lower_bound,
    output logic [MEM_ADDR:0]    mem_upper_bound,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error
);

    state_e                 r_state;
    state_e                 w_state_d;
    logic                   r_last;
    logic [NREQ-1:0]        r_owner;
    logic [MEM_ADDR:0]      r_mem_addr;
    logic [MEM_EXTRA-1:0]   r_mem_extra;
    logic [MEM_ADDR:0]      r_mem_lb;
    logic [MEM_ADDR:0]      r_mem_ub;
    logic [NREQ-1:0]        w_pick;
    logic                   w_sel;

    rr_picker u_picker (
        .i_req  (req),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    assign w_sel           = onehot_to_idx(gnt);
    assign mem_addr        = r_mem_addr;
    assign mem_extra       = r_mem_extra;
    assign mem_lower_bound = r_mem_lb;
    assign mem_upper_bound = r_mem_ub;

    // Next state and combinational outputs; everything is held quiet while reset is low.
    always_comb begin
        w_state_d = r_state;
        gnt       = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_error = 1'b0;
        if (reset) begin
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        gnt       = w_pick;
                        w_state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    w_state_d = RESP;
                end
                RESP: begin
                    rsp_valid = r_owner;
                    rsp_error = mem_error;
                    // An erroring fetch never leaks ROM contents.
                    rsp_data  = mem_error ? '0 : mem_data;
                    w_state_d = IDLE;
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    // State, round-robin pointer, owner and the registered ROM request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= '0;
            r_mem_addr  <= '0;
            r_mem_extra <= '0;
            r_mem_lb    <= '0;
            r_mem_ub    <= '0;
        end else begin
            r_state <= w_state_d;
            if (|gnt) begin
                r_last      <= w_sel;
                r_owner     <= gnt;
                r_mem_addr  <= w_sel ? req_addr1  : req_addr0;
                r_mem_extra <= w_sel ? req_extra1 : req_extra0;
                r_mem_lb    <= w_sel ? req_lb1    : req_lb0;
                r_mem_ub    <= w_sel ? req_ub1    : req_ub0;
            end
        end
    end

endmodule
